// File: rtl/cpu_pkg.sv
// Shared widths and write-back source encodings for the 16-bit pipelined RISC core.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_IMM = 1'b1;

endpackage

// File: rtl/wb_mux2.sv
// Parameterised 2:1 mux choosing between the ALU result and the immediate/LDM value.
module wb_mux2
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         sel,
  input  logic [W-1:0] alu_value,
  input  logic [W-1:0] immediate_value,
  output logic [W-1:0] y
);

  // Plain conditional so an unknown select propagates rather than being masked.
  assign y = (sel == WB_SEL_IMM) ? immediate_value : alu_value;

endmodule

// File: rtl/write_back_stage_unit.sv
// WB stage: combinational write-back select plus the registered register-file write port.
module write_back_stage_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic [DATA_W_P-1:0] immediate_value,
  input  logic [DATA_W_P-1:0] alu_value,
  input  logic                wb_en_in,
  input  logic [ADDR_W_P-1:0] wb_addr_in,
  output logic [DATA_W_P-1:0] data,
  output logic                wb_en,
  output logic [ADDR_W_P-1:0] wb_addr,
  output logic [DATA_W_P-1:0] wb_data
);

  wb_mux2 #(
    .W(DATA_W_P)
  ) u_mux (
    .sel             (sel),
    .alu_value       (alu_value),
    .immediate_value (immediate_value),
    .y               (data)
  );

  // Address and data are captured even when the write is disabled; consumers gate on wb_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en   <= wb_en_in;
      wb_addr <= wb_addr_in;
      wb_data <= data;
    end
  end

endmodule

// File: tb/tb_write_back_stage_unit.sv
// Self-checking bench for write_back_stage_unit using a queue of expected register-port values.
module tb_write_back_stage_unit;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic        sel;
  logic [15:0] immediate_value;
  logic [15:0] alu_value;
  logic        wb_en_in;
  logic [2:0]  wb_addr_in;
  logic [15:0] data;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  typedef struct packed {
    logic        en;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t exp_v;
  int   checks;
  int   errors;

  write_back_stage_unit dut (
    .clk             (clk),
    .rst             (rst),
    .sel             (sel),
    .immediate_value (immediate_value),
    .alu_value       (alu_value),
    .wb_en_in        (wb_en_in),
    .wb_addr_in      (wb_addr_in),
    .data            (data),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one WB transaction and record what the register port must show after the next edge.
  task automatic drive(input logic s, input logic [15:0] imm, input logic [15:0] alu,
                       input logic en, input logic [2:0] addr, input logic r);
    exp_t e;
    sel             = s;
    immediate_value = imm;
    alu_value       = alu;
    wb_en_in        = en;
    wb_addr_in      = addr;
    rst             = r;
    if (r) e = '0;
    else begin
      e.en   = en;
      e.addr = addr;
      e.data = s ? imm : alu;
    end
    sb.push_back(e);
  endtask

  task automatic test_comb_no_clock();
    clk_run         = 1'b0;
    rst             = 1'b0;
    immediate_value = 16'd150;
    alu_value       = 16'd120;
    sel             = 1'b0;
    #1;
    checks++;
    if (data !== 16'd120) begin
      errors++;
      $display("[TB] FAIL comb_sel0 data=%0d expected=%0d", data, 120);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (data !== 16'd150) begin
      errors++;
      $display("[TB] FAIL comb_sel1 data=%0d expected=%0d", data, 150);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    wb_en_in   = 1'b1;
    wb_addr_in = 3'd5;
    sel        = 1'b0;
    clk_run    = 1'b1;
    tick();
    tick();
    checks++;
    if (wb_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_en wb_en=%0b expected=0", wb_en);
    end
    checks++;
    if (wb_addr !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_addr wb_addr=%0d expected=0", wb_addr);
    end
    checks++;
    if (wb_data !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_data wb_data=%h expected=0000", wb_data);
    end
    drive(1'b0, 16'd150, 16'd120, 1'b1, 3'd5, 1'b0);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_release got en=%0b addr=%0d data=%h expected en=%0b addr=%0d data=%h",
               wb_en, wb_addr, wb_data, exp_v.en, exp_v.addr, exp_v.data);
    end
  endtask

  task automatic test_full_width();
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 3'd7, 1'b0);
    #1;
    checks++;
    if (data !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL full_width_comb data=%h expected=ffff", data);
    end
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== exp_v) begin
      errors++;
      $display("[TB] FAIL full_width got en=%0b addr=%0d data=%h expected en=%0b addr=%0d data=%h",
               wb_en, wb_addr, wb_data, exp_v.en, exp_v.addr, exp_v.data);
    end
  endtask

  task automatic test_sel_toggle();
    logic s;
    immediate_value = 16'hAAAA;
    alu_value       = 16'h5555;
    s               = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = s;
      #1;
      checks++;
      if (data !== (s ? 16'hAAAA : 16'h5555)) begin
        errors++;
        $display("[TB] FAIL toggle_comb step=%0d data=%h sel=%0b", i, data, s);
      end
      s = ~s;
    end
    drive(1'b0, 16'hAAAA, 16'h5555, 1'b1, 3'd2, 1'b0);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== exp_v) begin
      errors++;
      $display("[TB] FAIL toggle_edge got en=%0b addr=%0d data=%h expected en=%0b addr=%0d data=%h",
               wb_en, wb_addr, wb_data, exp_v.en, exp_v.addr, exp_v.data);
    end
    sel = 1'b1;
    #2;
    checks++;
    if (wb_data !== 16'h5555 || data !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL toggle_hold wb_data=%h expected=5555 data=%h expected=aaaa", wb_data, data);
    end
  endtask

  task automatic test_en_low();
    drive(1'b0, 16'h0F0F, 16'h1234, 1'b0, 3'd6, 1'b0);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== exp_v) begin
      errors++;
      $display("[TB] FAIL en_low got en=%0b addr=%0d data=%h expected en=%0b addr=%0d data=%h",
               wb_en, wb_addr, wb_data, exp_v.en, exp_v.addr, exp_v.data);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 16'h00AA, 16'h00BB, 1'b1, 3'd4, 1'b1);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({wb_en, wb_addr, wb_data} !== exp_v) begin
      errors++;
      $display("[TB] FAIL mid_reset got en=%0b addr=%0d data=%h expected en=%0b addr=%0d data=%h",
               wb_en, wb_addr, wb_data, exp_v.en, exp_v.addr, exp_v.data);
    end
    checks++;
    if (data !== 16'h00BB) begin
      errors++;
      $display("[TB] FAIL mid_reset_comb data=%h expected=00bb", data);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 16'hDEAD, 16'(10 * i), 1'b1, 3'(i), 1'b0);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if ({wb_en, wb_addr, wb_data} !== exp_v) begin
        errors++;
        $display("[TB] FAIL b2b_%0d got en=%0b addr=%0d data=%h expected en=%0b addr=%0d data=%h",
                 i, wb_en, wb_addr, wb_data, exp_v.en, exp_v.addr, exp_v.data);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      drive(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
            3'($urandom), ($urandom_range(0, 7) == 0));
      tick();
      exp_v = sb.pop_front();
      checks++;
      if ({wb_en, wb_addr, wb_data} !== exp_v) begin
        errors++;
        $display("[TB] FAIL random_%0d got en=%0b addr=%0d data=%h expected en=%0b addr=%0d data=%h",
                 i, wb_en, wb_addr, wb_data, exp_v.en, exp_v.addr, exp_v.data);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    clk_run         = 1'b0;
    rst             = 1'b0;
    sel             = 1'b0;
    immediate_value = '0;
    alu_value       = '0;
    wb_en_in        = 1'b0;
    wb_addr_in      = '0;
    test_comb_no_clock();
    test_reset();
    test_full_width();
    test_sel_toggle();
    test_en_low();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
